// File: rtl/decode_stage_fwd_if.sv
// Bundle of every non-clock/reset signal of the decode stage.
// master: the decode stage itself; slave: the fetch/GRF/forwarding/execute side.
interface decode_stage_fwd_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_FWD  = 2
);
    // Fetch side
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_inst;
    logic [DATA_W-1:0]         in_pc4;

    // Register file read ports
    logic [4:0]                grf_addr_1;
    logic [4:0]                grf_addr_2;
    logic [DATA_W-1:0]         grf_data_1;
    logic [DATA_W-1:0]         grf_data_2;

    // Forwarding channels, index 0 is the youngest producer
    logic [N_FWD-1:0]          fwd_valid;
    logic [N_FWD-1:0]          fwd_pending;
    logic [5*N_FWD-1:0]        fwd_addr;
    logic [DATA_W*N_FWD-1:0]   fwd_data;

    // Execute side
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_inst;
    logic [DATA_W-1:0]         out_rs;
    logic [DATA_W-1:0]         out_rt;
    logic [DATA_W-1:0]         out_imm;
    logic [DATA_W-1:0]         out_do;

    // Fetch redirect
    logic                      pc_jump;
    logic [DATA_W-1:0]         npc_target;

    modport master (
        input  in_valid, in_inst, in_pc4,
        output in_ready,
        output grf_addr_1, grf_addr_2,
        input  grf_data_1, grf_data_2,
        input  fwd_valid, fwd_pending, fwd_addr, fwd_data,
        output out_valid, out_inst, out_rs, out_rt, out_imm, out_do,
        input  out_ready,
        output pc_jump, npc_target
    );

    modport slave (
        output in_valid, in_inst, in_pc4,
        input  in_ready,
        input  grf_addr_1, grf_addr_2,
        output grf_data_1, grf_data_2,
        output fwd_valid, fwd_pending, fwd_addr, fwd_data,
        input  out_valid, out_inst, out_rs, out_rt, out_imm, out_do,
        output out_ready,
        input  pc_jump, npc_target
    );
endinterface

// File: rtl/decode_stage_fwd.sv
// MIPS instruction-decode stage: IF/ID register, GRF read with operand
// forwarding and hazard stall, branch/jump resolution in ID (one delay slot,
// never flushes) and an ID/EX output register with valid/ready handshake.
module decode_stage_fwd #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_FWD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    decode_stage_fwd_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [DATA_W-1:0] LINK_OFS = {{(DATA_W-3){1'b0}}, 3'b100};

    // IF/ID register
    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_inst_q, id_inst_d;
    logic [DATA_W-1:0] id_pc4_q, id_pc4_d;

    // ID/EX register
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [DATA_W-1:0] out_rs_q, out_rs_d;
    logic [DATA_W-1:0] out_rt_q, out_rt_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [DATA_W-1:0] out_do_q, out_do_d;

    // Decode
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm16;
    logic        is_addu, is_subu, is_ori, is_lui, is_lw, is_sw;
    logic        is_beq, is_bne, is_j, is_jal, is_jr;
    logic        rs_used, rt_used;

    // Operand resolution
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              rs_hit, rt_hit;
    logic              rs_stall, rt_stall;
    logic              hazard;
    logic              advance;
    logic              accept;

    // Immediates and ID-computed values
    logic [DATA_W-1:0] imm_sext, imm_zext;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] do_val;
    logic [DATA_W-1:0] br_target, j_target;
    logic              pc_jump;
    logic [DATA_W-1:0] npc_target;

    // An empty IF/ID register presents an all-zero word, which is the nop.
    assign inst    = id_valid_q ? id_inst_q : 32'h0;
    assign opcode  = inst[31:26];
    assign funct   = inst[5:0];
    assign rs_addr = inst[25:21];
    assign imm16   = inst[15:0];

    // Opcode decode; unsupported encodings fall through as nop.
    always_comb begin
        is_addu = 1'b0;
        is_subu = 1'b0;
        is_jr   = 1'b0;
        is_ori  = 1'b0;
        is_lui  = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_jal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: is_addu = 1'b1;
                    FN_SUBU: is_subu = 1'b1;
                    FN_JR:   is_jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  is_ori = 1'b1;
            OP_LUI:  is_lui = 1'b1;
            OP_LW:   is_lw  = 1'b1;
            OP_SW:   is_sw  = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            default: ;
        endcase
    end

    assign rs_used = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_bne | is_jr;
    assign rt_used = is_addu | is_subu | is_sw | is_beq | is_bne;
    // Port 2 reads $0 when rt is unused so it can never match a producer.
    assign rt_addr = rt_used ? inst[20:16] : 5'd0;

    assign bus.grf_addr_1 = rs_addr;
    assign bus.grf_addr_2 = rt_addr;

    // Operand resolution: first matching channel wins, even if it is pending.
    always_comb begin
        rs_val   = bus.grf_data_1;
        rt_val   = bus.grf_data_2;
        rs_hit   = 1'b0;
        rt_hit   = 1'b0;
        rs_stall = 1'b0;
        rt_stall = 1'b0;
        for (int i = 0; i < N_FWD; i++) begin
            if (!rs_hit && bus.fwd_valid[i] && (bus.fwd_addr[5*i +: 5] == rs_addr)) begin
                rs_hit = 1'b1;
                if (bus.fwd_pending[i]) begin
                    rs_stall = 1'b1;
                end else begin
                    rs_val = bus.fwd_data[DATA_W*i +: DATA_W];
                end
            end
            if (!rt_hit && bus.fwd_valid[i] && (bus.fwd_addr[5*i +: 5] == rt_addr)) begin
                rt_hit = 1'b1;
                if (bus.fwd_pending[i]) begin
                    rt_stall = 1'b1;
                end else begin
                    rt_val = bus.fwd_data[DATA_W*i +: DATA_W];
                end
            end
        end
        // $0 is hardwired: ignore GRF contents and any producer claiming it.
        if (rs_addr == 5'd0) begin
            rs_val   = '0;
            rs_stall = 1'b0;
        end
        if (rt_addr == 5'd0) begin
            rt_val   = '0;
            rt_stall = 1'b0;
        end
    end

    assign hazard  = (rs_used & rs_stall) | (rt_used & rt_stall);
    assign advance = id_valid_q & ~hazard & (~out_valid_q | bus.out_ready);
    assign accept  = bus.in_valid & bus.in_ready;

    assign bus.in_ready = ~id_valid_q | advance;

    assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, imm16};
    assign br_target = id_pc4_q + (imm_sext << 2);
    assign j_target  = {id_pc4_q[DATA_W-1:28], inst[25:0], 2'b00};

    // Immediate extension and the value produced directly in ID.
    always_comb begin
        imm_ext = '0;
        do_val  = '0;
        if (is_ori || is_lui) begin
            imm_ext = imm_zext;
        end else if (is_lw || is_sw || is_beq || is_bne) begin
            imm_ext = imm_sext;
        end
        if (is_jal) begin
            do_val = id_pc4_q + LINK_OFS;
        end else if (is_lui) begin
            do_val = imm_zext << 16;
        end
    end

    // Fetch redirect, only while the branch/jump actually leaves ID.
    always_comb begin
        pc_jump    = 1'b0;
        npc_target = '0;
        if (advance) begin
            if (is_beq) begin
                pc_jump    = (rs_val == rt_val);
                npc_target = br_target;
            end else if (is_bne) begin
                pc_jump    = (rs_val != rt_val);
                npc_target = br_target;
            end else if (is_j || is_jal) begin
                pc_jump    = 1'b1;
                npc_target = j_target;
            end else if (is_jr) begin
                pc_jump    = 1'b1;
                npc_target = rs_val;
            end
        end
    end

    assign bus.pc_jump    = pc_jump;
    assign bus.npc_target = npc_target;

    // IF/ID next state: load on accept, drain on advance, else hold.
    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc4_d   = id_pc4_q;
        if (accept) begin
            id_valid_d = 1'b1;
            id_inst_d  = bus.in_inst;
            id_pc4_d   = bus.in_pc4;
        end else if (advance) begin
            id_valid_d = 1'b0;
        end
    end

    // ID/EX next state: load on advance, bubble when consumed, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_rs_d    = out_rs_q;
        out_rt_d    = out_rt_q;
        out_imm_d   = out_imm_q;
        out_do_d    = out_do_q;
        if (advance) begin
            out_valid_d = 1'b1;
            out_inst_d  = inst;
            out_rs_d    = rs_val;
            out_rt_d    = rt_val;
            out_imm_d   = imm_ext;
            out_do_d    = do_val;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid_q  <= 1'b0;
            id_inst_q   <= 32'h0;
            id_pc4_q    <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_rs_q    <= '0;
            out_rt_q    <= '0;
            out_imm_q   <= '0;
            out_do_q    <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc4_q    <= id_pc4_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_rs_q    <= out_rs_d;
            out_rt_q    <= out_rt_d;
            out_imm_q   <= out_imm_d;
            out_do_q    <= out_do_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_rs    = out_rs_q;
    assign bus.out_rt    = out_rt_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_do    = out_do_q;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed bench for decode_stage_fwd: reset, forwarding, stall, branch/jump
// redirect, back-pressure hold and immediate extension.
module tb_decode_stage_fwd;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_FWD  = 2;

    localparam logic [31:0] I_ORI  = 32'h3405_1234; // ori  $5,$0,0x1234
    localparam logic [31:0] I_JAL  = 32'h0C00_0C01; // jal  0x0C01
    localparam logic [31:0] I_LUI  = 32'h3C06_8001; // lui  $6,0x8001
    localparam logic [31:0] I_ADDU = 32'h0022_1821; // addu $3,$1,$2
    localparam logic [31:0] I_JR   = 32'h0020_0008; // jr   $1
    localparam logic [31:0] I_BEQ  = 32'h1084_FFFF; // beq  $4,$4,-1
    localparam logic [31:0] I_BNE  = 32'h1484_0002; // bne  $4,$4,2
    localparam logic [31:0] I_LW   = 32'h8C27_FFF8; // lw   $7,-8($1)

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] rf [32];

    decode_stage_fwd_if #(.DATA_W(DATA_W), .N_FWD(N_FWD)) bus ();

    decode_stage_fwd #(.DATA_W(DATA_W), .N_FWD(N_FWD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file model answering the DUT read addresses.
    assign bus.grf_data_1 = rf[bus.grf_addr_1];
    assign bus.grf_data_2 = rf[bus.grf_addr_2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int ch, input logic v, input logic p,
                           input logic [4:0] a, input logic [31:0] d);
        bus.fwd_valid[ch]         = v;
        bus.fwd_pending[ch]       = p;
        bus.fwd_addr[5*ch +: 5]   = a;
        bus.fwd_data[32*ch +: 32] = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[4] = 32'h44;
        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_inst     = 32'h0;
        bus.in_pc4      = 32'h0;
        bus.out_ready   = 1'b1;
        bus.fwd_valid   = '0;
        bus.fwd_pending = '0;
        bus.fwd_addr    = '0;
        bus.fwd_data    = '0;

        // Reset state
        #3;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        chk("rst_pc_jump",   {31'b0, bus.pc_jump},   32'd0);
        chk("rst_npc",       bus.npc_target,         32'h0);
        chk("rst_out_inst",  bus.out_inst,           32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Back-pressure: ORI sits in ID/EX while JAL waits in IF/ID
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_inst   = I_ORI;
        bus.in_pc4    = 32'h3000;
        bus.out_ready = 1'b0;
        tick();
        bus.in_inst = I_JAL;
        bus.in_pc4  = 32'h3008;
        #1;
        chk("hold_accept_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("hold_out_inst",  bus.out_inst,           I_ORI);
            chk("hold_out_imm",   bus.out_imm,            32'h0000_1234);
            chk("hold_in_ready",  {31'b0, bus.in_ready},  32'd0);
            chk("hold_pc_jump",   {31'b0, bus.pc_jump},   32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("jal_pc_jump",  {31'b0, bus.pc_jump}, 32'd1);
        chk("jal_npc",      bus.npc_target,       32'h0000_3004);
        chk("jal_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("jal_out_inst", bus.out_inst, I_JAL);
        chk("jal_out_do",   bus.out_do,   32'h0000_300C);

        // Asynchronous reset mid-cycle with a valid instruction in ID/EX
        bus.out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mr_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mr_out_inst",  bus.out_inst,           32'h0);
        chk("mr_out_do",    bus.out_do,             32'h0);
        chk("mr_pc_jump",   {31'b0, bus.pc_jump},   32'd0);
        chk("mr_npc",       bus.npc_target,         32'h0);
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = I_LUI;
        bus.in_pc4    = 32'h3010;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("lat_pre_valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("lat_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("lui_out_inst",  bus.out_inst,           I_LUI);
        chk("lui_out_do",    bus.out_do,             32'h8001_0000);
        chk("lui_out_imm",   bus.out_imm,            32'h0000_8001);

        // Forwarding from channel 1, channel 0 idle
        set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_fwd(1, 1'b1, 1'b0, 5'd2, 32'd9);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_ADDU;
        bus.in_pc4   = 32'h3014;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("fwd1_out_rs", bus.out_rs, 32'd5);
        chk("fwd1_out_rt", bus.out_rt, 32'd9);
        chk("fwd1_out_do", bus.out_do, 32'h0);

        // Pending channel 0 masks ready channel 1 and stalls
        set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h77);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_ADDU;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
            tick();
            chk("stall_bubble", {31'b0, bus.out_valid}, 32'd0);
        end
        set_fwd(0, 1'b1, 1'b0, 5'd2, 32'h77);
        #1;
        chk("unstall_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("unstall_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("unstall_out_rs",    bus.out_rs,             32'd5);
        chk("unstall_out_rt",    bus.out_rt,             32'h77);

        // jr with rs forwarded from channel 0
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h4000);
        set_fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_JR;
        bus.in_pc4   = 32'h3020;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("jr_pc_jump", {31'b0, bus.pc_jump}, 32'd1);
        chk("jr_npc",     bus.npc_target,       32'h4000);
        tick();
        chk("jr_out_rs", bus.out_rs, 32'h4000);

        // A pending producer on $0 never stalls and $0 reads as zero
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_ORI;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("r0_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("r0_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("r0_out_rs",    bus.out_rs,             32'h0);

        // Taken beq, delay-slot instruction still accepted
        set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_BEQ;
        bus.in_pc4   = 32'h3004;
        tick();
        bus.in_inst = I_ORI;
        bus.in_pc4  = 32'h3008;
        #1;
        chk("beq_pc_jump",  {31'b0, bus.pc_jump}, 32'd1);
        chk("beq_npc",      bus.npc_target,       32'h0000_3000);
        chk("beq_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("beq_out_inst",  bus.out_inst,         I_BEQ);
        chk("beq_out_imm",   bus.out_imm,          32'hFFFF_FFFF);
        chk("slot_pc_jump",  {31'b0, bus.pc_jump}, 32'd0);
        tick();
        chk("slot_out_inst", bus.out_inst, I_ORI);

        // Not-taken bne
        bus.in_valid = 1'b1;
        bus.in_inst  = I_BNE;
        bus.in_pc4   = 32'h3010;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("bne_pc_jump", {31'b0, bus.pc_jump}, 32'd0);
        tick();

        // lw sign-extended offset
        bus.in_valid = 1'b1;
        bus.in_inst  = I_LW;
        bus.in_pc4   = 32'h3014;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("lw_out_imm", bus.out_imm, 32'hFFFF_FFF8);
        chk("lw_out_rs",  bus.out_rs,  32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_fwd.md
Name: decode_stage_fwd

Overview:
- Registered MIPS instruction-decode pipeline stage with an IF/ID input register, operand forwarding and an ID/EX output register.
- Reads the GRF and resolves operands from N_FWD forwarding channels, stalling on pending producers.
- Resolves branches and jumps in ID with one architectural delay slot.
- Sits between fetch and execute, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, datapath width; immediate, link and target arithmetic are performed at this width.
N_FWD, 2, number of forwarding channels; channel 0 is the youngest producer and has highest priority.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage accepts the instruction this cycle.
in_inst  input  32  instruction word.
in_pc4  input  DATA_W  PC+4 of the instruction.
grf_addr_1  output  5  GRF read address, always rs of the held instruction.
grf_addr_2  output  5  GRF read address: rt of the held instruction, or 0 when rt is unused.
grf_data_1  input  DATA_W  GRF read data for port 1, combinational.
grf_data_2  input  DATA_W  GRF read data for port 2, combinational.
fwd_valid  input  N_FWD  channel i will write register fwd_addr[i].
fwd_pending  input  N_FWD  channel i data is not yet available.
fwd_addr  input  5*N_FWD  destination register of channel i (bits 5i+4:5i).
fwd_data  input  DATA_W*N_FWD  result of channel i.
out_valid  output  1  ID/EX register holds a valid instruction.
out_ready  input  1  execute consumes the ID/EX contents.
out_inst  output  32  decoded instruction word.
out_rs  output  DATA_W  resolved rs operand.
out_rt  output  DATA_W  resolved rt operand.
out_imm  output  DATA_W  extended immediate.
out_do  output  DATA_W  ID-computed result: link address, lui value, or 0.
pc_jump  output  1  redirect fetch to npc_target.
npc_target  output  DATA_W  redirect target.

Behaviour:
- Reset (asynchronous, reset=0): IF/ID valid=0, out_valid=0, and all out_* registers=0.
  - pc_jump=0 and npc_target=0 while reset is asserted and thereafter until an advancing branch.
  - An instruction in flight is discarded.
- IF/ID register:
  - Loads in_inst and in_pc4 when in_valid & in_ready.
  - in_ready = !id_valid | advance.
  - When id_valid=0, combinational outputs act as for a nop.
- Supported opcodes: addu, subu, ori, lui, lw, sw, beq, bne, j, jal, jr, nop. Anything else decodes as nop.
- Source usage:
  - rs is used by addu, subu, ori, lw, sw, beq, bne, jr.
  - rt is used by addu, subu, sw, beq, bne.
  - An unused source never stalls.
- Register 0 is never forwarded and never stalls; it always reads as 0.
- Forwarding resolution, per used source r:
  - Scan channels in order 0..N_FWD-1 and take the first with fwd_valid[i] & fwd_addr[i]==r.
  - If that channel's fwd_pending=1, hazard=1.
  - Otherwise the operand is fwd_data[i].
  - With no matching channel, the operand is the GRF data.
  - A lower-index match masks all higher indices, even if a higher index is non-pending.
- advance = id_valid & !hazard & (!out_valid | out_ready).
- ID/EX register: on advance, load out_inst, the resolved operands, out_imm and out_do, and set out_valid=1.
- On a stall (id_valid & hazard) or an empty stage:
  - If out_ready=1, out_valid goes to 0 (bubble).
  - If out_ready=0, the register holds unchanged.
- Immediate extension: ori and lui are zero-extended; lw, sw, beq and bne are sign-extended to DATA_W.
- out_do: jal gives pc4+4; lui gives imm<<16; all other instructions give 0.
- Branch and jump control is combinational, gated by advance; pc_jump=0 whenever advance=0.
  - beq/bne: pc_jump = (rs==rt) / (rs!=rt) on resolved operands; npc_target = pc4 + (sext(imm)<<2), modulo 2^DATA_W.
  - j/jal: pc_jump=1; npc_target = {pc4[DATA_W-1:28], addr26, 2'b00}.
  - jr: pc_jump=1; npc_target = resolved rs.
- Delay slot: the instruction following a branch is accepted and executed normally; the stage never flushes.
- Simultaneous stall and out_ready=0: the IF/ID and ID/EX registers both hold; in_ready=0.

Test Plan:
1. Reset asserted mid-stream while out_valid=1 -> out_valid, out_* and pc_jump become 0 immediately, with no clock required; the first instruction after release appears on out_* exactly 1 cycle after acceptance.
2. `addu $3,$1,$2` with GRF $1=5, $2=7; fwd channel 1 non-pending writes $2=9; channel 0 invalid -> out_rs=5, out_rt=9.
3. Same instruction with channel 0 matching $2 and pending, and channel 1 non-pending on $2 -> stall: in_ready=0 and out_valid=0 (bubble) for each pending cycle; advances with out_rt=fwd_data[0] on the cycle pending drops.
4. `beq $4,$4,-1` at pc4=0x3004 -> pc_jump=1 and npc_target=0x3000 in the advance cycle; the following instruction is still accepted.
5. `jal 0x0C01` at pc4=0x3008 -> npc_target=0x00003004; out_do=0x300C.
6. out_ready=0 for 3 cycles with a valid instruction held -> out_* stable, in_ready=0, pc_jump=0 throughout; resumes on out_ready=1.
